// File: rtl/aclk_multi_alarm.sv
// aclk_multi_alarm: N_AL independent alarm channels for the alarm clock.
// Each channel holds an alarm time (hh:mm), rings when the running time hits
// hh:mm:00 on a second boundary, supports snooze, and stops ringing by itself
// after RING_SEC unattended seconds. Alarm is the OR of all ringing channels.
//
// Strobe semantics: sec_tick and LD_al are single-cycle strobes with no
// back-pressure; they are acted on in the cycle they are high. STOP_al and
// AL_ON are levels. SNOOZE is sampled every cycle.
module aclk_multi_alarm #(
    parameter int N_AL       = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int IW        = (N_AL > 1) ? $clog2(N_AL) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [4:0]        cur_h,
    input  logic [5:0]        cur_m,
    input  logic [5:0]        cur_s,
    input  logic              LD_al,
    input  logic [IW-1:0]     ld_idx,
    input  logic [4:0]        ld_h,
    input  logic [5:0]        ld_m,
    input  logic [N_AL-1:0]   AL_ON,
    input  logic              STOP_al,
    input  logic              SNOOZE,
    output logic              Alarm,
    output logic [N_AL-1:0]   ringing,
    output logic [N_AL-1:0]   snoozed,
    output logic [2*N_AL-1:0] dbg_state
);

    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int MAX_TICKS = (RING_SEC > SNZ_TICKS) ? RING_SEC : SNZ_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] RING_LAST = CW'(RING_SEC - 1);
    localparam logic [CW-1:0] SNZ_LAST  = CW'(SNZ_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_SNZ  = 2'd2
    } ch_state_t;

    // A load is only honoured when index and time are all in range.
    logic load_ok;
    assign load_ok = LD_al && (int'(ld_idx) < N_AL) && (ld_h <= 5'd23) && (ld_m <= 6'd59);

    genvar i;
    generate
        for (i = 0; i < N_AL; i++) begin : g_ch
            ch_state_t     st;
            logic [CW-1:0] cnt;
            logic [4:0]    al_h;
            logic [5:0]    al_m;
            logic          ring_q;
            logic          snz_q;
            logic          load_hit;
            logic          match;

            assign load_hit = load_ok && (int'(ld_idx) == i);
            assign match    = sec_tick && AL_ON[i] && (cur_h == al_h) &&
                              (cur_m == al_m) && (cur_s == 6'd0);

            // Per-channel alarm FSM; ring_q/snz_q are registered copies of the state.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    st     <= ST_IDLE;
                    cnt    <= '0;
                    al_h   <= '0;
                    al_m   <= '0;
                    ring_q <= 1'b0;
                    snz_q  <= 1'b0;
                end else if (load_hit) begin
                    // A load beats everything, including a same-cycle match on the old time.
                    al_h   <= ld_h;
                    al_m   <= ld_m;
                    st     <= ST_IDLE;
                    cnt    <= '0;
                    ring_q <= 1'b0;
                    snz_q  <= 1'b0;
                end else begin
                    case (st)
                        ST_IDLE: begin
                            // A match while STOP_al is held is swallowed.
                            if (match && !STOP_al) begin
                                st     <= ST_RING;
                                cnt    <= '0;
                                ring_q <= 1'b1;
                            end
                        end
                        ST_RING: begin
                            if (STOP_al || !AL_ON[i]) begin
                                st     <= ST_IDLE;
                                ring_q <= 1'b0;
                            end else if (SNOOZE) begin
                                st     <= ST_SNZ;
                                cnt    <= '0;
                                ring_q <= 1'b0;
                                snz_q  <= 1'b1;
                            end else if (sec_tick) begin
                                if (cnt == RING_LAST) begin
                                    st     <= ST_IDLE;
                                    ring_q <= 1'b0;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        ST_SNZ: begin
                            if (STOP_al || !AL_ON[i]) begin
                                st    <= ST_IDLE;
                                snz_q <= 1'b0;
                            end else if (sec_tick) begin
                                if (cnt == SNZ_LAST) begin
                                    // Back to ringing with a fresh RING_SEC window.
                                    st     <= ST_RING;
                                    cnt    <= '0;
                                    ring_q <= 1'b1;
                                    snz_q  <= 1'b0;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            st     <= ST_IDLE;
                            ring_q <= 1'b0;
                            snz_q  <= 1'b0;
                        end
                    endcase
                end
            end

            assign ringing[i]         = ring_q;
            assign snoozed[i]         = snz_q;
            assign dbg_state[2*i +: 2] = st;
        end
    endgenerate

    // Shared buzzer: OR of the per-channel ringing flops.
    assign Alarm = |ringing;

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// Directed bench for aclk_multi_alarm with default parameters
// (4 channels, 5 minute snooze, 60 second ring timeout).
module tb_aclk_multi_alarm;

    localparam int N  = 4;
    localparam int W  = 1 + N + N + 2 * N;

    logic           clk;
    logic           reset;
    logic           sec_tick;
    logic [4:0]     cur_h;
    logic [5:0]     cur_m;
    logic [5:0]     cur_s;
    logic           LD_al;
    logic [1:0]     ld_idx;
    logic [4:0]     ld_h;
    logic [5:0]     ld_m;
    logic [N-1:0]   AL_ON;
    logic           STOP_al;
    logic           SNOOZE;
    logic           Alarm;
    logic [N-1:0]   ringing;
    logic [N-1:0]   snoozed;
    logic [2*N-1:0] dbg_state;

    aclk_multi_alarm #(.N_AL(4), .SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
        .LD_al(LD_al), .ld_idx(ld_idx), .ld_h(ld_h), .ld_m(ld_m),
        .AL_ON(AL_ON), .STOP_al(STOP_al), .SNOOZE(SNOOZE),
        .Alarm(Alarm), .ringing(ringing), .snoozed(snoozed), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           errors = 0;
    int           checks = 0;

    // Expected observation; channel state is derived from ring/snooze intent.
    function automatic logic [W-1:0] mk(logic a, logic [N-1:0] r, logic [N-1:0] s);
        logic [2*N-1:0] d;
        for (int k = 0; k < N; k++) d[2*k +: 2] = r[k] ? 2'd1 : (s[k] ? 2'd2 : 2'd0);
        return {a, r, s, d};
    endfunction

    task automatic expect_out(string t, logic [W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_out();
        logic [W-1:0] e;
        logic [W-1:0] obs;
        string        t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {Alarm, ringing, snoozed, dbg_state};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, obs, e);
        end
    endtask

    // Drivers
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_h = h; cur_m = m; cur_s = s; sec_tick = 1'b1;
    endtask

    task automatic set_load(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m);
        LD_al = 1'b1; ld_idx = idx; ld_h = h; ld_m = m;
    endtask

    // Push expectation, apply one edge, drop the strobes, compare.
    task automatic step(string t, logic [W-1:0] e);
        expect_out(t, e);
        clk1();
        sec_tick = 1'b0; LD_al = 1'b0; SNOOZE = 1'b0;
        check_out();
    endtask

    // Non-matching second ticks, each followed by an idle cycle.
    task automatic run_ticks(int n);
        for (int k = 0; k < n; k++) begin
            set_tick(5'd12, 6'd0, 6'd1);
            clk1();
            sec_tick = 1'b0;
            clk1();
        end
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0; cur_h = '0; cur_m = '0; cur_s = 6'd1;
        LD_al = 1'b0; ld_idx = '0; ld_h = '0; ld_m = '0;
        AL_ON = '0; STOP_al = 1'b0; SNOOZE = 1'b0;
        clk1(); clk1();
        expect_out("reset_state", mk(0, 4'b0000, 4'b0000));
        check_out();
        reset = 1'b0;
        clk1();

        // Basic match on channel 0
        set_load(2'd0, 5'd7, 6'd30); AL_ON = 4'b0001;
        step("load_ch0", mk(0, 4'b0000, 4'b0000));
        set_tick(5'd7, 6'd30, 6'd0);
        step("match_ring", mk(1, 4'b0001, 4'b0000));
        set_tick(5'd7, 6'd30, 6'd1);
        step("no_retrigger", mk(1, 4'b0001, 4'b0000));

        // Ring timeout: 07:30:01 was tick 1, 58 more gives 59
        run_ticks(58);
        expect_out("pre_timeout", mk(1, 4'b0001, 4'b0000));
        check_out();
        set_tick(5'd12, 6'd0, 6'd1);
        step("timeout", mk(0, 4'b0000, 4'b0000));

        // Snooze cycle
        set_tick(5'd7, 6'd30, 6'd0);
        step("ring_for_snooze", mk(1, 4'b0001, 4'b0000));
        SNOOZE = 1'b1;
        step("snooze", mk(0, 4'b0000, 4'b0001));
        run_ticks(299);
        expect_out("snooze_hold", mk(0, 4'b0000, 4'b0001));
        check_out();
        set_tick(5'd12, 6'd0, 6'd1);
        step("snooze_expire", mk(1, 4'b0001, 4'b0000));
        run_ticks(59);
        expect_out("full_ring_again", mk(1, 4'b0001, 4'b0000));
        check_out();
        STOP_al = 1'b1;
        step("stop", mk(0, 4'b0000, 4'b0000));
        STOP_al = 1'b0;

        // STOP_al beats SNOOZE
        set_tick(5'd7, 6'd30, 6'd0);
        step("ring_for_stop", mk(1, 4'b0001, 4'b0000));
        STOP_al = 1'b1; SNOOZE = 1'b1;
        step("stop_beats_snooze", mk(0, 4'b0000, 4'b0000));

        // Match consumed while STOP_al held
        set_tick(5'd7, 6'd30, 6'd0);
        step("match_under_stop", mk(0, 4'b0000, 4'b0000));
        STOP_al = 1'b0;
        step("match_consumed", mk(0, 4'b0000, 4'b0000));

        // Two channels at once
        set_load(2'd1, 5'd6, 6'd0);
        step("load_ch1", mk(0, 4'b0000, 4'b0000));
        set_load(2'd2, 5'd6, 6'd0);
        step("load_ch2", mk(0, 4'b0000, 4'b0000));
        AL_ON = 4'b0111;
        set_tick(5'd6, 6'd0, 6'd0);
        step("multi_ring", mk(1, 4'b0110, 4'b0000));
        AL_ON = 4'b0101;
        step("drop_en1", mk(1, 4'b0100, 4'b0000));
        AL_ON = 4'b0001;
        step("drop_en2", mk(0, 4'b0000, 4'b0000));

        // Invalid loads are ignored entirely; a valid one silences the channel
        set_tick(5'd7, 6'd30, 6'd0);
        step("ring_for_load", mk(1, 4'b0001, 4'b0000));
        set_load(2'd0, 5'd24, 6'd0);
        step("bad_hour_ignored", mk(1, 4'b0001, 4'b0000));
        set_load(2'd0, 5'd7, 6'd60);
        step("bad_min_ignored", mk(1, 4'b0001, 4'b0000));
        set_load(2'd0, 5'd8, 6'd15);
        step("load_while_ring", mk(0, 4'b0000, 4'b0000));
        set_tick(5'd7, 6'd30, 6'd0);
        step("old_time_gone", mk(0, 4'b0000, 4'b0000));
        set_tick(5'd8, 6'd15, 6'd0);
        step("new_time_rings", mk(1, 4'b0001, 4'b0000));
        STOP_al = 1'b1;
        step("stop_new", mk(0, 4'b0000, 4'b0000));
        STOP_al = 1'b0;

        // Load and match in the same cycle: load wins
        set_load(2'd0, 5'd9, 6'd0);
        set_tick(5'd8, 6'd15, 6'd0);
        step("load_beats_match", mk(0, 4'b0000, 4'b0000));
        set_tick(5'd9, 6'd0, 6'd0);
        step("ring_0900", mk(1, 4'b0001, 4'b0000));

        // Asynchronous reset mid-ring
        reset = 1'b1;
        #2;
        expect_out("async_reset", mk(0, 4'b0000, 4'b0000));
        check_out();
        clk1();
        reset = 1'b0;
        AL_ON = 4'b1111;
        set_tick(5'd0, 6'd0, 6'd0);
        step("reset_times_zero", mk(1, 4'b1111, 4'b0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
